localbus_sender_ml: RTL and testbench

- Parametrised successor to the two-lane localbus sender.
- Serialises up to MAX_UNIT_NUM units of UNIT_BIT_NUM bits over LANE_NUM data lanes, with a forwarded clock CLK_O and a frame-enable DE_O.
- Adds an optional per-unit even-parity beat and back-to-back frame chaining (DE_O held high) via CONTINUE_I.
- Sits at the FPGA boundary and feeds the multi-lane localbus parser.

---
 rtl/localbus_sender_ml.sv | 179 +++++++++++++++++
 tb/tb_localbus_sender_ml.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/localbus_sender_ml.sv
// Multi-lane localbus sender: serialises a frame of units over LANE_NUM lanes next to a
// forwarded CLK_I/2 clock, with an optional per-unit parity beat and back-to-back frame chaining.
module localbus_sender_ml #(
  parameter int MAX_UNIT_NUM = 4,
  parameter int UNIT_BIT_NUM = 32,
  parameter int LANE_NUM     = 2,
  parameter int PARITY_EN    = 0
) (
  input  logic                                 CLK_I,
  input  logic                                 RST_I,
  input  logic [MAX_UNIT_NUM*UNIT_BIT_NUM-1:0] PDATA_I,
  input  logic [7:0]                           VALID_UNIT_NUM_I,
  input  logic                                 START_I,
  input  logic                                 CONTINUE_I,
  output logic                                 CLK_O,
  output logic                                 DE_O,
  output logic [LANE_NUM-1:0]                  DQ_O,
  output logic                                 ALMOST_PULSE_O,
  output logic                                 BUSY_O,
  output logic                                 FRAME_DONE_O
);
  localparam int DATA_BEATS     = UNIT_BIT_NUM / LANE_NUM;
  localparam int BEATS_PER_UNIT = DATA_BEATS + ((PARITY_EN != 0) ? 1 : 0);
  localparam int PW             = MAX_UNIT_NUM * UNIT_BIT_NUM;
  localparam int UW             = $clog2(MAX_UNIT_NUM + 1);
  localparam int BW             = $clog2(BEATS_PER_UNIT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_UNIT - 1);
  localparam bit ONE_BEAT_UNIT  = (BEATS_PER_UNIT == 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_SEND, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic              de_q, de_d;
  logic [LANE_NUM-1:0] dq_q, dq_d;
  logic              almost_q, almost_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [UW-1:0]     unit_q, unit_d;
  logic [UW-1:0]     n_q, n_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [PW-1:0]     data_q, data_d;
  logic [UW-1:0]     n_last;
  logic [UW-1:0]     n_new;

  // Lane L of beat b is unit bit b*LANE_NUM+L; the beat after the data beats is even parity on lane 0.
  function automatic logic [LANE_NUM-1:0] beat_val(input logic [PW-1:0] data,
                                                   input logic [UW-1:0] unit,
                                                   input logic [BW-1:0] beat);
    logic [UNIT_BIT_NUM-1:0] u_bits;
    u_bits   = data[int'(unit)*UNIT_BIT_NUM +: UNIT_BIT_NUM];
    beat_val = '0;
    if (int'(beat) >= DATA_BEATS) beat_val[0] = ^u_bits;
    else                          beat_val    = u_bits[int'(beat)*LANE_NUM +: LANE_NUM];
  endfunction

  function automatic logic [UW-1:0] clamp_n(input logic [7:0] v);
    if (int'(v) > MAX_UNIT_NUM) clamp_n = UW'(MAX_UNIT_NUM);
    else                        clamp_n = UW'(v);
  endfunction

  always_comb begin
    state_d  = state_q;
    phase_d  = ~phase_q;
    de_d     = de_q;
    dq_d     = dq_q;
    almost_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unit_d   = unit_q;
    beat_d   = beat_q;
    n_d      = n_q;
    data_d   = data_q;
    n_last   = UW'(n_q - 1'b1);
    n_new    = clamp_n(VALID_UNIT_NUM_I);

    case (state_q)
      S_IDLE: begin
        if (START_I && (VALID_UNIT_NUM_I != 8'd0)) begin
          data_d  = PDATA_I;
          n_d     = n_new;
          busy_d  = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        // Outputs only move on the edge entering a phase-0 cycle, so wait for phase 1 here.
        if (phase_q) begin
          de_d   = 1'b1;
          unit_d = '0;
          beat_d = '0;
          dq_d   = beat_val(data_q, '0, '0);
          if (ONE_BEAT_UNIT && (n_q == UW'(1))) begin
            almost_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d  = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (phase_q) begin
          if (beat_q == LAST_BEAT) begin
            unit_d = unit_q + 1'b1;
            beat_d = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
          dq_d = beat_val(data_q, unit_d, beat_d);
          if ((unit_d == n_last) && (beat_d == LAST_BEAT)) begin
            almost_d = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!phase_q) begin
          done_d = 1'b1;
        end else if (CONTINUE_I && (VALID_UNIT_NUM_I != 8'd0)) begin
          data_d = PDATA_I;
          n_d    = n_new;
          unit_d = '0;
          beat_d = '0;
          dq_d   = beat_val(PDATA_I, '0, '0);
          if (ONE_BEAT_UNIT && (n_new == UW'(1))) begin
            almost_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d  = S_SEND;
          end
        end else begin
          de_d    = 1'b0;
          dq_d    = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= S_IDLE;
      phase_q  <= 1'b0;
      de_q     <= 1'b0;
      dq_q     <= '0;
      almost_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      unit_q   <= '0;
      beat_q   <= '0;
      n_q      <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      de_q     <= de_d;
      dq_q     <= dq_d;
      almost_q <= almost_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      unit_q   <= unit_d;
      beat_q   <= beat_d;
      n_q      <= n_d;
    end
  end

  // NOTE: the payload register is left out of reset; it is always reloaded before it is read.
  always_ff @(posedge CLK_I) begin
    data_q <= data_d;
  end

  assign CLK_O          = phase_q;
  assign DE_O           = de_q;
  assign DQ_O           = dq_q;
  assign ALMOST_PULSE_O = almost_q;
  assign BUSY_O         = busy_q;
  assign FRAME_DONE_O   = done_q;
endmodule

// File: tb/tb_localbus_sender_ml.sv
// Bench for localbus_sender_ml: a 2-lane plain instance and a 4-lane parity instance, each
// checked beat-by-beat against a scoreboard queue plus frame-level length/pulse checks.
module tb_localbus_sender_ml;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] a_pdata, b_pdata;
  logic [7:0]   a_valid, b_valid;
  logic         a_start, a_cont, b_start, b_cont;
  logic         a_clko, a_de, a_almost, a_busy, a_done;
  logic         b_clko, b_de, b_almost, b_busy, b_done;
  logic [1:0]   a_dq;
  logic [3:0]   b_dq;

  localbus_sender_ml #(.MAX_UNIT_NUM(4), .UNIT_BIT_NUM(32), .LANE_NUM(2), .PARITY_EN(0)) dut_a (
    .CLK_I(clk), .RST_I(rst), .PDATA_I(a_pdata), .VALID_UNIT_NUM_I(a_valid),
    .START_I(a_start), .CONTINUE_I(a_cont), .CLK_O(a_clko), .DE_O(a_de), .DQ_O(a_dq),
    .ALMOST_PULSE_O(a_almost), .BUSY_O(a_busy), .FRAME_DONE_O(a_done));

  localbus_sender_ml #(.MAX_UNIT_NUM(4), .UNIT_BIT_NUM(32), .LANE_NUM(4), .PARITY_EN(1)) dut_b (
    .CLK_I(clk), .RST_I(rst), .PDATA_I(b_pdata), .VALID_UNIT_NUM_I(b_valid),
    .START_I(b_start), .CONTINUE_I(b_cont), .CLK_O(b_clko), .DE_O(b_de), .DQ_O(b_dq),
    .ALMOST_PULSE_O(b_almost), .BUSY_O(b_busy), .FRAME_DONE_O(b_done));

  typedef struct {
    logic [127:0] pdata;
    logic [7:0]   valid;
    int           units;
    logic [1:0]   first;
    logic [1:0]   last;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: expected beats per instance, pushed when a frame is requested.
  logic [7:0] a_exp[$];
  logic [7:0] b_exp[$];

  task automatic push_a(input logic [127:0] pd, input int n);
    logic [31:0] w;
    for (int u = 0; u < n; u++) begin
      w = 32'(pd >> (u * 32));
      for (int b = 0; b < 16; b++) begin
        a_exp.push_back({6'b0, w[1:0]});
        w = w >> 2;
      end
    end
  endtask

  task automatic push_b(input logic [127:0] pd, input int n);
    logic [31:0] w;
    logic        par;
    for (int u = 0; u < n; u++) begin
      w   = 32'(pd >> (u * 32));
      par = ^w;
      for (int b = 0; b < 8; b++) begin
        b_exp.push_back({4'b0, w[3:0]});
        w = w >> 4;
      end
      b_exp.push_back({7'b0, par});
    end
  endtask

  // Monitor state, sampled on the falling edge.
  int         a_run, a_de_len, a_beats, a_fd_cnt, a_alm_cnt, a_rise;
  int         b_run, b_de_len, b_beats, b_fd_cnt, b_alm_cnt, b_rise;
  logic [1:0] a_first, a_last, a_prev_dq;
  logic [3:0] b_prev_dq;
  logic       a_prev_de, a_prev_alm, b_prev_de, b_prev_alm;
  logic [3:0] b_hist[64];
  logic [7:0] e;

  always @(negedge clk) begin
    if (rst) begin
      a_run = 0;
      b_run = 0;
    end else begin
      if (a_clko) begin
        check("a_de_stable_phase1", a_de, a_prev_de);
        check("a_dq_stable_phase1", a_dq, a_prev_dq);
      end
      if (a_de && !a_prev_de) a_rise++;
      if (a_de) a_run++;
      else if (a_run != 0) begin a_de_len = a_run; a_run = 0; end
      if (a_de && !a_clko) begin
        check("a_beat_expected", a_exp.size() != 0, 1);
        if (a_exp.size() != 0) begin
          e = a_exp.pop_front();
          check("a_beat", a_dq, e);
        end
        if (a_beats == 0) a_first = a_dq;
        a_last = a_dq;
        a_beats++;
      end
      if (a_almost) begin
        a_alm_cnt++;
        check("a_almost_one_cycle", a_prev_alm, 0);
      end
      if (a_done) begin
        a_fd_cnt++;
        check("a_almost_before_done", a_prev_alm, 1);
      end

      if (b_clko) begin
        check("b_de_stable_phase1", b_de, b_prev_de);
        check("b_dq_stable_phase1", b_dq, b_prev_dq);
      end
      if (b_de && !b_prev_de) b_rise++;
      if (b_de) b_run++;
      else if (b_run != 0) begin b_de_len = b_run; b_run = 0; end
      if (b_de && !b_clko) begin
        check("b_beat_expected", b_exp.size() != 0, 1);
        if (b_exp.size() != 0) begin
          e = b_exp.pop_front();
          check("b_beat", b_dq, e);
        end
        if (b_beats < 64) b_hist[b_beats] = b_dq;
        b_beats++;
      end
      if (b_almost) b_alm_cnt++;
      if (b_done) begin
        b_fd_cnt++;
        check("b_almost_before_done", b_prev_alm, 1);
      end
    end
    a_prev_de  = a_de;
    a_prev_dq  = a_dq;
    a_prev_alm = a_almost;
    b_prev_de  = b_de;
    b_prev_dq  = b_dq;
    b_prev_alm = b_almost;
  end

  task automatic clr_a();
    a_de_len = 0; a_beats = 0; a_fd_cnt = 0; a_alm_cnt = 0; a_rise = 0;
  endtask

  task automatic clr_b();
    b_de_len = 0; b_beats = 0; b_fd_cnt = 0; b_alm_cnt = 0; b_rise = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input int budget);
    int k = 0;
    while ((a_busy || a_de) && k < budget) begin tick(); k++; end
    check("a_idle_within_budget", a_busy, 0);
    repeat (2) tick();
  endtask

  task automatic wait_idle_b(input int budget);
    int k = 0;
    while ((b_busy || b_de) && k < budget) begin tick(); k++; end
    check("b_idle_within_budget", b_busy, 0);
    repeat (2) tick();
  endtask

  task automatic check_a_frame(input string tag, input int units);
    check({tag, "_de_len"}, a_de_len, 32 * units);
    check({tag, "_beats"}, a_beats, 16 * units);
    check({tag, "_frame_done"}, a_fd_cnt, 1);
    check({tag, "_almost"}, a_alm_cnt, 1);
    check({tag, "_de_rises"}, a_rise, 1);
    check({tag, "_queue_empty"}, a_exp.size(), 0);
    check({tag, "_busy_after"}, a_busy, 0);
    check({tag, "_dq_after"}, a_dq, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[5];
    int         lat;
    int         k;
    logic       c0;
    logic [127:0] p1, p2;

    vecs[0] = '{128'hffeeddcc_11223344_55667788_aa55aa55, 8'd4, 4, 2'b01, 2'b11};
    vecs[1] = '{128'hffeeddcc_11223344_55667788_aa55aa55, 8'd9, 4, 2'b01, 2'b11};
    vecs[2] = '{128'h00000000_00000000_00000000_c0000002, 8'd1, 1, 2'b10, 2'b11};
    vecs[3] = '{128'h00000000_00000000_40000003_12345678, 8'd2, 2, 2'b00, 2'b01};
    vecs[4] = '{128'h01234567_89abcdef_fedcba98_76543210, 8'd0, 0, 2'b00, 2'b00};

    rst = 1'b1;
    a_pdata = '0; a_valid = '0; a_start = 1'b0; a_cont = 1'b0;
    b_pdata = '0; b_valid = '0; b_start = 1'b0; b_cont = 1'b0;
    repeat (3) tick();
    check("reset_a_clko", a_clko, 0);
    check("reset_a_de", a_de, 0);
    check("reset_a_dq", a_dq, 0);
    check("reset_a_busy", a_busy, 0);
    check("reset_a_almost", a_almost, 0);
    check("reset_a_done", a_done, 0);
    check("reset_b_de", b_de, 0);
    check("reset_b_dq", b_dq, 0);
    check("reset_b_busy", b_busy, 0);
    rst = 1'b0;
    c0 = a_clko;
    tick();
    check("clko_toggles", a_clko, !c0);

    for (int i = 0; i < 5; i++) begin
      clr_a();
      a_pdata = vecs[i].pdata;
      a_valid = vecs[i].valid;
      if (vecs[i].units == 0) begin
        a_start = 1'b1;
        repeat (6) begin
          tick();
          check($sformatf("v%0d_busy_stays_low", i), a_busy, 0);
        end
        a_start = 1'b0;
        repeat (4) tick();
        check($sformatf("v%0d_no_de", i), a_rise, 0);
        check($sformatf("v%0d_no_frame_done", i), a_fd_cnt, 0);
      end else begin
        push_a(vecs[i].pdata, vecs[i].units);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check($sformatf("v%0d_busy_at_arm", i), a_busy, 1);
        lat = 0;
        while (!a_de && lat < 4) begin tick(); lat++; end
        check($sformatf("v%0d_arm_latency_1_or_2", i), (lat == 1) || (lat == 2), 1);
        repeat (8) tick();
        a_pdata = ~vecs[i].pdata;
        a_valid = 8'd3;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        wait_idle_a(400);
        check_a_frame($sformatf("v%0d", i), vecs[i].units);
        check($sformatf("v%0d_first_beat", i), a_first, vecs[i].first);
        check($sformatf("v%0d_last_beat", i), a_last, vecs[i].last);
      end
    end

    // Chained frames: N=1 then N=2 with CONTINUE held through the first frame's last beat.
    clr_a();
    p1 = 128'h00000000_00000000_00000000_0f0f0f0f;
    p2 = 128'h00000000_00000000_2468ace0_13579bdf;
    push_a(p1, 1);
    push_a(p2, 2);
    a_pdata = p1; a_valid = 8'd1; a_start = 1'b1;
    tick();
    a_start = 1'b0; a_pdata = p2; a_valid = 8'd2; a_cont = 1'b1;
    k = 0;
    while (a_fd_cnt < 1 && k < 100) begin tick(); k++; end
    a_cont = 1'b0;
    check("chain_first_done_seen", a_fd_cnt, 1);
    wait_idle_a(400);
    check("chain_de_len", a_de_len, 96);
    check("chain_de_rises", a_rise, 1);
    check("chain_frame_done", a_fd_cnt, 2);
    check("chain_almost", a_alm_cnt, 2);
    check("chain_beats", a_beats, 48);
    check("chain_queue_empty", a_exp.size(), 0);

    // Reset during unit 2 abandons the frame; a fresh start then sends a clean frame.
    clr_a();
    push_a(vecs[0].pdata, 4);
    a_pdata = vecs[0].pdata; a_valid = 8'd4; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    k = 0;
    while (a_beats < 40 && k < 400) begin tick(); k++; end
    check("rst_reached_unit2", a_beats >= 40, 1);
    rst = 1'b1;
    tick();
    check("rst_mid_de", a_de, 0);
    check("rst_mid_dq", a_dq, 0);
    check("rst_mid_busy", a_busy, 0);
    check("rst_mid_clko", a_clko, 0);
    check("rst_mid_almost", a_almost, 0);
    rst = 1'b0;
    a_exp.delete();
    repeat (6) tick();
    check("rst_no_frame_done", a_fd_cnt, 0);
    check("rst_stays_idle", a_busy, 0);
    clr_a();
    push_a(vecs[0].pdata, 4);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_idle_a(400);
    check_a_frame("post_rst", 4);

    // Parity instance: 4 lanes, units 1 and 3 -> parity beats 1 then 0.
    clr_b();
    p1 = 128'h00000000_00000000_00000003_00000001;
    push_b(p1, 2);
    b_pdata = p1; b_valid = 8'd2; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    wait_idle_b(400);
    check("par_de_len", b_de_len, 36);
    check("par_beats", b_beats, 18);
    check("par_frame_done", b_fd_cnt, 1);
    check("par_almost", b_alm_cnt, 1);
    check("par_beat8", b_hist[8], 4'b0001);
    check("par_beat17", b_hist[17], 4'b0000);
    check("par_queue_empty", b_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
